// File: rtl/aes128_decrypt_iter.sv
// ---------------------------------------------------------------------------
// aes128_decrypt_iter
//   Iterative AES-128 inverse cipher, one round per clock.
//   Round keys are generated on the fly. A forward expansion runs from the
//   cipher key up to round key 10, then an inverse expansion steps back down
//   to round key 0 while the rounds execute. Round key 10 is cached, so later
//   blocks under the same key skip the forward expansion.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   start       request, sampled only while idle
//   new_key     with start: 1 = expand key_in, 0 = reuse the cached key
//   key_in      128-bit cipher key, byte 0 at [127:120]
//   cipher_in   128-bit ciphertext, byte 0 at [127:120], column-major
//   plain_out   128-bit plaintext, held until the next completion
//   busy        high while a block is in flight
//   done        one-cycle completion pulse
//   round_count current round index, for debug
// ---------------------------------------------------------------------------
module aes128_decrypt_iter (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         new_key,
  input  logic [127:0] key_in,
  input  logic [127:0] cipher_in,
  output logic [127:0] plain_out,
  output logic         busy,
  output logic         done,
  output logic [3:0]   round_count
);

  localparam int NR = 10;
  localparam int NK = 4;

  typedef enum logic [2:0] {IDLE, KEYGEN, INIT_ARK, ROUND, FINAL} fsm_t;

  // ---------------- GF(2^8) helpers (polynomial 0x11B) ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x;
    x = ginv(a);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
             ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] y;
    y = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return ginv(y);
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon_lut(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // ---------------- Registers ----------------
  fsm_t         fsm_reg, fsm_next;
  logic [127:0] state_reg;
  logic [127:0] rk_reg;
  logic [127:0] cached_rk10;
  logic         key_valid;
  logic [3:0]   kidx_reg;

  // ---------------- Cipher datapath ----------------
  // InvShiftRows is pure wiring: output row r, column c takes input column
  // (c - r) mod 4. InvSubBytes follows directly on each byte.
  logic [127:0] isb_vec;

  for (genvar gi = 0; gi < 16; gi++) begin : g_inv_sub_shift
    localparam int ROW = gi % 4;
    localparam int COL = gi / 4;
    localparam int SRC = 4 * ((COL + 4 - ROW) % 4) + ROW;
    assign isb_vec[127-8*gi -: 8] = inv_sbox(state_reg[127-8*SRC -: 8]);
  end

  logic [127:0] final_block;
  logic [127:0] round_block;
  assign final_block = isb_vec ^ rk_reg;
  assign round_block = inv_mix_columns(final_block);

  // ---------------- Key schedule ----------------
  // Forward and inverse steps both need SubWord(RotWord(x)) ^ Rcon. Forward
  // applies it to w3 of the current key; inverse applies it to the recovered
  // w3 of the previous key (w3 ^ w2). One shared set of S-boxes serves both.
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] sw_in, rot_word, sub_word, t_word;
  logic [3:0]  rcon_idx;
  logic [127:0] fwd_key, inv_key;

  assign w0 = rk_reg[127:96];
  assign w1 = rk_reg[95:64];
  assign w2 = rk_reg[63:32];
  assign w3 = rk_reg[31:0];

  assign sw_in    = (fsm_reg == KEYGEN) ? w3 : (w3 ^ w2);
  assign rot_word = {sw_in[23:0], sw_in[31:24]};

  for (genvar gi = 0; gi < NK; gi++) begin : g_key_sbox
    assign sub_word[31-8*gi -: 8] = sbox(rot_word[31-8*gi -: 8]);
  end

  always_comb begin
    rcon_idx = round_count;
    case (fsm_reg)
      KEYGEN:   rcon_idx = kidx_reg;
      INIT_ARK: rcon_idx = 4'(NR);
      default:  rcon_idx = round_count;
    endcase
  end

  assign t_word = sub_word ^ {rcon_lut(rcon_idx), 24'h000000};

  always_comb begin
    logic [31:0] n0, n1, n2;
    n0 = w0 ^ t_word;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    fwd_key = {n0, n1, n2, w3 ^ n2};
  end

  assign inv_key = {w0 ^ t_word, w1 ^ w0, w2 ^ w1, w3 ^ w2};

  // ---------------- Control FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) fsm_reg <= IDLE;
    else        fsm_reg <= fsm_next;
  end

  always_comb begin
    fsm_next = fsm_reg;
    case (fsm_reg)
      IDLE: begin
        if (start) fsm_next = (new_key || !key_valid) ? KEYGEN : INIT_ARK;
      end
      KEYGEN:   if (kidx_reg == 4'(NR)) fsm_next = INIT_ARK;
      INIT_ARK: fsm_next = ROUND;
      ROUND:    if (round_count == 4'd1) fsm_next = FINAL;
      FINAL:    fsm_next = IDLE;
      default:  fsm_next = IDLE;
    endcase
  end

  // ---------------- Datapath registers ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= '0;
      rk_reg      <= '0;
      cached_rk10 <= '0;
      key_valid   <= 1'b0;
      kidx_reg    <= 4'd0;
      plain_out   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      round_count <= 4'd0;
    end else begin
      done <= 1'b0;
      case (fsm_reg)
        IDLE: begin
          if (start) begin
            state_reg <= cipher_in;
            busy      <= 1'b1;
            // A reuse request with nothing cached falls back to expansion.
            if (new_key || !key_valid) begin
              rk_reg   <= key_in;
              kidx_reg <= 4'd1;
            end else begin
              rk_reg <= cached_rk10;
            end
          end
        end
        KEYGEN: begin
          rk_reg <= fwd_key;
          if (kidx_reg == 4'(NR)) begin
            cached_rk10 <= fwd_key;
            key_valid   <= 1'b1;
          end else begin
            kidx_reg <= kidx_reg + 4'd1;
          end
        end
        INIT_ARK: begin
          state_reg   <= state_reg ^ rk_reg;
          rk_reg      <= inv_key;
          round_count <= 4'(NR - 1);
        end
        ROUND: begin
          state_reg   <= round_block;
          rk_reg      <= inv_key;
          round_count <= round_count - 4'd1;
        end
        FINAL: begin
          plain_out   <= final_block;
          done        <= 1'b1;
          busy        <= 1'b0;
          round_count <= 4'd0;
        end
        default: ;
      endcase
    end
  end

endmodule
